mem_stage_responder: RTL and testbench

Data-memory responder for the MEM stage of the 24-bit pipeline. It accepts one read or write request per instruction from the MEM stage and services it against an internal word array after a fixed number of wait states. While a request is outstanding it holds the `stall` output high to the pipeline registers, then returns read data for capture into the MEM-to-WB register. It is the memory-side end of the `mem_read_enable` / `mem_read_data` path feeding writeback.

---
 rtl/mem_stage_responder.sv | 108 ++++++++++
 tb/tb_mem_stage_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_responder.sv
// MEM-stage data-memory responder: services one load/store per instruction
// against an internal word array after WAIT_CYCLES wait states, stalling the pipeline meanwhile.
module mem_stage_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_read,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [23:0]          req_wdata,
    output logic                 stall,
    output logic                 rdata_valid,
    output logic [23:0]          rdata,
    output logic                 err
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam int         DEPTH     = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t                 state_q;
    logic [3:0]             cnt_q;
    logic                   is_write_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [23:0]            wdata_q;
    logic [23:0]            rdata_q;
    logic                   rdata_valid_q;
    logic                   err_q;
    logic [23:0]            mem_q [DEPTH];

    logic single_req;
    logic both_req;
    logic commit;

    assign single_req = req_read ^ req_write;
    assign both_req   = req_read & req_write;
    // The access completes on the edge that leaves WAIT with the counter exhausted.
    assign commit     = (state_q == WAIT) && (cnt_q == 4'd0);

    // Gated by rst so the combinational IDLE stall cannot leak out while reset is held.
    assign stall       = rst && ((state_q == WAIT) || ((state_q == IDLE) && single_req));
    assign rdata_valid = rdata_valid_q;
    assign rdata       = rdata_q;
    assign err         = err_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            is_write_q    <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= 24'd0;
            rdata_q       <= 24'd0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (single_req) begin
                        is_write_q <= req_write;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        cnt_q      <= WAIT_INIT;
                        state_q    <= WAIT;
                    end else if (both_req) begin
                        err_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= DONE;
                        if (!is_write_q) begin
                            rdata_q       <= mem_q[addr_q];
                            rdata_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Request inputs here belong to the instruction just serviced.
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the word array has no reset; its contents are undefined at power-up
    // and survive rst, and a reset flop per word would be wasted logic.
    always_ff @(posedge clk) begin
        if (commit && is_write_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_stage_responder.sv
// Self-checking bench for mem_stage_responder: table-driven accesses with a
// scoreboard queue, plus hand-written sequences for error, churn and reset corners.
module tb_mem_stage_responder;

    logic        clk;
    logic        rst;
    logic        req_read   [2];
    logic        req_write  [2];
    logic [7:0]  req_addr   [2];
    logic [23:0] req_wdata  [2];
    logic        stall      [2];
    logic        rdata_valid[2];
    logic [23:0] rdata      [2];
    logic        err        [2];

    int checks;
    int failures;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [23:0] wdata;
        logic        exp_v;
        logic [23:0] exp_d;
    } vec_t;

    typedef struct {
        logic        v;
        logic [23:0] d;
    } exp_t;

    vec_t        vecs [9];
    exp_t        sb_q [$];
    logic [23:0] last_rdata [2];

    // Instance 0 runs with two wait states, instance 1 with none.
    mem_stage_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_read   (req_read[0]),
        .req_write  (req_write[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .stall      (stall[0]),
        .rdata_valid(rdata_valid[0]),
        .rdata      (rdata[0]),
        .err        (err[0])
    );

    mem_stage_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_read   (req_read[1]),
        .req_write  (req_write[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .stall      (stall[1]),
        .rdata_valid(rdata_valid[1]),
        .rdata      (rdata[1]),
        .err        (err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issues one access, counts stall cycles, and checks the DONE cycle against the scoreboard.
    task automatic access(input int s, input logic wr, input logic [7:0] a, input logic [23:0] wd,
                          input logic exp_v, input logic [23:0] exp_d, input int exp_stall,
                          input bit churn, input string name);
        exp_t e;
        int   n;
        bit   done;
        e.v = exp_v;
        e.d = exp_d;
        sb_q.push_back(e);
        req_read[s]  = !wr;
        req_write[s] = wr;
        req_addr[s]  = a;
        req_wdata[s] = wd;
        @(negedge clk);
        check({name, " stall_on_request"}, 32'(stall[s]), 32'd1);
        n = 1;
        @(posedge clk) #1;
        req_read[s]  = 1'b0;
        req_write[s] = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (churn) begin
                req_addr[s]  = (i % 2 == 0) ? 8'h04 : 8'h06;
                req_wdata[s] = 24'($urandom);
            end
            @(negedge clk);
            if (stall[s]) begin
                n++;
                check({name, " rdata_hold"}, 32'(rdata[s]), 32'(last_rdata[s]));
                check({name, " valid_low_in_wait"}, 32'(rdata_valid[s]), 32'd0);
            end else begin
                done = 1'b1;
            end
            if (!done) @(posedge clk) #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: stall never dropped, got %0d cycles expected %0d", name, n, exp_stall);
            void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            check({name, " stall_cycles"}, 32'(n), 32'(exp_stall));
            check({name, " rdata_valid"}, 32'(rdata_valid[s]), 32'(e.v));
            check({name, " rdata"}, 32'(rdata[s]), 32'(e.d));
            check({name, " err_quiet"}, 32'(err[s]), 32'd0);
        end
        last_rdata[s] = exp_d;
        @(posedge clk) #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req_read[s]   = 1'b0;
            req_write[s]  = 1'b0;
            req_addr[s]   = 8'h00;
            req_wdata[s]  = 24'h0;
            last_rdata[s] = 24'h0;
        end

        vecs[0] = '{1'b1, 8'h10, 24'hABCDEF, 1'b0, 24'h000000};
        vecs[1] = '{1'b0, 8'h10, 24'h000000, 1'b1, 24'hABCDEF};
        vecs[2] = '{1'b1, 8'h01, 24'h0A0A0A, 1'b0, 24'hABCDEF};
        vecs[3] = '{1'b1, 8'h02, 24'h0B0B0B, 1'b0, 24'hABCDEF};
        vecs[4] = '{1'b0, 8'h01, 24'h000000, 1'b1, 24'h0A0A0A};
        vecs[5] = '{1'b0, 8'h02, 24'h000000, 1'b1, 24'h0B0B0B};
        vecs[6] = '{1'b1, 8'h20, 24'h111111, 1'b0, 24'h0B0B0B};
        vecs[7] = '{1'b1, 8'h04, 24'h444444, 1'b0, 24'h0B0B0B};
        vecs[8] = '{1'b1, 8'h06, 24'h666666, 1'b0, 24'h0B0B0B};

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("reset stall", 32'(stall[s]), 32'd0);
            check("reset rdata_valid", 32'(rdata_valid[s]), 32'd0);
            check("reset rdata", 32'(rdata[s]), 32'd0);
            check("reset err", 32'(err[s]), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk) #1;

        // Table-driven accesses, issued back-to-back at the minimum period.
        for (int i = 0; i < 9; i++) begin
            access(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_v, vecs[i].exp_d,
                   4, 1'b0, $sformatf("vec%0d", i));
        end

        // Zero wait states.
        access(1, 1'b1, 8'hFF, 24'h000001, 1'b0, 24'h000000, 2, 1'b0, "w0_write_ff");
        access(1, 1'b0, 8'hFF, 24'h000000, 1'b1, 24'h000001, 2, 1'b0, "w0_read_ff");

        // Address/data churn during WAIT must not leak into the store.
        access(0, 1'b1, 8'h05, 24'h123456, 1'b0, 24'h0B0B0B, 4, 1'b1, "churn_write_05");
        access(0, 1'b0, 8'h04, 24'h000000, 1'b1, 24'h444444, 4, 1'b0, "churn_read_04");
        access(0, 1'b0, 8'h05, 24'h000000, 1'b1, 24'h123456, 4, 1'b0, "churn_read_05");
        access(0, 1'b0, 8'h06, 24'h000000, 1'b1, 24'h666666, 4, 1'b0, "churn_read_06");

        // Both request lines high: ignored, err pulses once in the following cycle.
        req_read[0]  = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 8'h10;
        req_wdata[0] = 24'h999999;
        @(negedge clk);
        check("both stall", 32'(stall[0]), 32'd0);
        check("both err_not_yet", 32'(err[0]), 32'd0);
        @(posedge clk) #1;
        req_read[0]  = 1'b0;
        req_write[0] = 1'b0;
        @(negedge clk);
        check("both err_pulse", 32'(err[0]), 32'd1);
        check("both stall_after", 32'(stall[0]), 32'd0);
        @(posedge clk) #1;
        @(negedge clk);
        check("both err_cleared", 32'(err[0]), 32'd0);
        @(posedge clk) #1;
        access(0, 1'b0, 8'h10, 24'h000000, 1'b1, 24'hABCDEF, 4, 1'b0, "both_read_10");

        // Reset during WAIT of a store discards the store.
        req_write[0] = 1'b1;
        req_addr[0]  = 8'h20;
        req_wdata[0] = 24'h777777;
        @(posedge clk) #1;
        req_write[0] = 1'b0;
        @(negedge clk);
        check("rstmid stall_in_wait", 32'(stall[0]), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("rstmid stall", 32'(stall[0]), 32'd0);
        check("rstmid rdata_valid", 32'(rdata_valid[0]), 32'd0);
        check("rstmid rdata", 32'(rdata[0]), 32'd0);
        check("rstmid err", 32'(err[0]), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rstmid valid_held_low", 32'(rdata_valid[0]), 32'd0);
        rst = 1'b1;
        last_rdata[0] = 24'h0;
        @(posedge clk) #1;
        access(0, 1'b0, 8'h20, 24'h000000, 1'b1, 24'h111111, 4, 1'b0, "rstmid_read_20");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
